// File: rtl/exu_hazard_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package exu_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN,
      LSTALL,
      FLUSH
   } hz_state_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/exu_hazard_ctrl_fwd_select.sv
// Per-operand forwarding select: youngest writer (EX, then MEM, then WB) wins; x0 never forwards.
module fwd_select
   import exu_hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs,
   input  logic       ex_valid,
   input  logic [4:0] ex_rd,
   input  logic       ex_R_wen,
   input  logic       ex_mem_ren,
   input  logic [4:0] mem_rd,
   input  logic       mem_R_wen,
   input  logic [4:0] wb_rd,
   input  logic       wb_R_wen,
   output fwd_sel_e   sel
);

   always_comb begin
      sel = FWD_RF;
      if (rs != REG_ZERO) begin
         // A load still in EX has no data yet; the load-use stall covers it.
         if (ex_valid && ex_R_wen && !ex_mem_ren && (ex_rd == rs)) begin
            sel = FWD_EX;
         end else if (mem_R_wen && (mem_rd == rs)) begin
            sel = FWD_MEM;
         end else if (wb_R_wen && (wb_rd == rs)) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/exu_hazard_ctrl.sv
// Execute-stage hazard control: load-use stalls, branch/jump redirect, flush windows, forwarding.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module exu_hazard_ctrl
   import exu_hazard_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES      = 2,
   parameter int unsigned LOAD_STALL_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic        ex_R_wen,
   input  logic        ex_mem_ren,
   input  logic        ex_jump_flag,
   input  logic        ex_branch_flag,
   input  logic        ex_result0,
   input  logic [31:0] ex_branch_pc,
   input  logic [4:0]  mem_rd,
   input  logic        mem_R_wen,
   input  logic        mem_mem_ren,
   input  logic [4:0]  wb_rd,
   input  logic        wb_R_wen,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        if_stall,
   output logic        id_stall,
   output logic        id_flush,
   output logic        EXU_inst_clr,
`ifdef HAZARD_PERF_EN
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt,
`endif
   output logic [1:0]  fwd_sel_rs1,
   output logic [1:0]  fwd_sel_rs2
);

   localparam logic [2:0] FLUSH_CNT_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
   localparam logic [2:0] LOAD_CNT_INIT  = (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;

   hz_state_e  state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       take, lu, do_redirect;
   fwd_sel_e   sel_rs1, sel_rs2;

   // Load data sitting in MEM uses the same MEM forwarding path as an ALU result.
   logic unused_mem_ren;
   assign unused_mem_ren = mem_mem_ren;

   assign take = ex_valid && (ex_jump_flag || (ex_branch_flag && ex_result0));
   assign lu   = id_valid && ex_valid && ex_mem_ren && ex_R_wen && (ex_rd != REG_ZERO) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
   assign do_redirect = take && (state_q != FLUSH);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if_stall       = 1'b0;
      id_stall       = 1'b0;
      id_flush       = 1'b0;
      EXU_inst_clr   = 1'b0;
      if (do_redirect) begin
         redirect_valid = 1'b1;
         redirect_pc    = ex_branch_pc;
         id_flush       = 1'b1;
         EXU_inst_clr   = 1'b1;
         state_d        = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
         cnt_d          = FLUSH_CNT_INIT;
      end else begin
         case (state_q)
            RUN: begin
               if (lu) begin
                  if_stall     = 1'b1;
                  id_stall     = 1'b1;
                  EXU_inst_clr = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     state_d = LSTALL;
                     cnt_d   = LOAD_CNT_INIT;
                  end
               end
            end
            LSTALL: begin
               if_stall     = 1'b1;
               id_stall     = 1'b1;
               EXU_inst_clr = 1'b1;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - 3'd1;
            end
            FLUSH: begin
               id_flush     = 1'b1;
               EXU_inst_clr = 1'b1;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - 3'd1;
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
      if (reset) begin
         redirect_valid = 1'b0;
         redirect_pc    = '0;
         if_stall       = 1'b0;
         id_stall       = 1'b0;
         id_flush       = 1'b0;
         EXU_inst_clr   = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   fwd_select u_fwd_rs1 (
      .rs         (id_rs1),
      .ex_valid   (ex_valid),
      .ex_rd      (ex_rd),
      .ex_R_wen   (ex_R_wen),
      .ex_mem_ren (ex_mem_ren),
      .mem_rd     (mem_rd),
      .mem_R_wen  (mem_R_wen),
      .wb_rd      (wb_rd),
      .wb_R_wen   (wb_R_wen),
      .sel        (sel_rs1)
   );

   fwd_select u_fwd_rs2 (
      .rs         (id_rs2),
      .ex_valid   (ex_valid),
      .ex_rd      (ex_rd),
      .ex_R_wen   (ex_R_wen),
      .ex_mem_ren (ex_mem_ren),
      .mem_rd     (mem_rd),
      .mem_R_wen  (mem_R_wen),
      .wb_rd      (wb_rd),
      .wb_R_wen   (wb_R_wen),
      .sel        (sel_rs2)
   );

   assign fwd_sel_rs1 = reset ? 2'b00 : sel_rs1;
   assign fwd_sel_rs2 = reset ? 2'b00 : sel_rs2;

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (id_stall && (perf_stall_q != '1))       perf_stall_d = perf_stall_q + 32'd1;
      if (redirect_valid && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_exu_hazard_ctrl.sv
// Scoreboard bench for exu_hazard_ctrl (default FLUSH_CYCLES=2, LOAD_STALL_CYCLES=1).
module tb_exu_hazard_ctrl;

   typedef struct packed {
      logic        rv;
      logic [31:0] pc;
      logic        ifs;
      logic        ids;
      logic        fl;
      logic        clr;
      logic [1:0]  f1;
      logic [1:0]  f2;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2;
   logic        id_rs1_used, id_rs2_used;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic        ex_R_wen, ex_mem_ren, ex_jump_flag, ex_branch_flag, ex_result0;
   logic [31:0] ex_branch_pc;
   logic [4:0]  mem_rd;
   logic        mem_R_wen, mem_mem_ren;
   logic [4:0]  wb_rd;
   logic        wb_R_wen;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_stall, id_stall, id_flush, EXU_inst_clr;
   logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   exu_hazard_ctrl #(
      .FLUSH_CYCLES      (2),
      .LOAD_STALL_CYCLES (1)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .id_valid       (id_valid),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rs1_used    (id_rs1_used),
      .id_rs2_used    (id_rs2_used),
      .ex_valid       (ex_valid),
      .ex_rd          (ex_rd),
      .ex_R_wen       (ex_R_wen),
      .ex_mem_ren     (ex_mem_ren),
      .ex_jump_flag   (ex_jump_flag),
      .ex_branch_flag (ex_branch_flag),
      .ex_result0     (ex_result0),
      .ex_branch_pc   (ex_branch_pc),
      .mem_rd         (mem_rd),
      .mem_R_wen      (mem_R_wen),
      .mem_mem_ren    (mem_mem_ren),
      .wb_rd          (wb_rd),
      .wb_R_wen       (wb_R_wen),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_stall       (if_stall),
      .id_stall       (id_stall),
      .id_flush       (id_flush),
      .EXU_inst_clr   (EXU_inst_clr),
`ifdef HAZARD_PERF_EN
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt),
`endif
      .fwd_sel_rs1    (fwd_sel_rs1),
      .fwd_sel_rs2    (fwd_sel_rs2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its end, passed=%0d total=%0d", n_pass, n_checks);
      $fatal(1, "timeout");
   end

   // Monitor: outputs are valid every cycle; compare at the falling edge.
   initial begin
      exp_t  e;
      exp_t  a;
      string nm;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{redirect_valid, redirect_pc, if_stall, id_stall, id_flush, EXU_inst_clr,
                   fwd_sel_rs1, fwd_sel_rs2};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got rv=%0b pc=%h ifs=%0b ids=%0b fl=%0b clr=%0b f1=%0d f2=%0d, want rv=%0b pc=%h ifs=%0b ids=%0b fl=%0b clr=%0b f1=%0d f2=%0d",
                          nm, a.rv, a.pc, a.ifs, a.ids, a.fl, a.clr, a.f1, a.f2,
                          e.rv, e.pc, e.ifs, e.ids, e.fl, e.clr, e.f1, e.f2);
         end
      end
   end

   task automatic clear_inputs();
      reset = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_valid = 1'b0; ex_rd = '0;
      ex_R_wen = 1'b0; ex_mem_ren = 1'b0; ex_jump_flag = 1'b0; ex_branch_flag = 1'b0;
      ex_result0 = 1'b0; ex_branch_pc = '0; mem_rd = '0; mem_R_wen = 1'b0;
      mem_mem_ren = 1'b0; wb_rd = '0; wb_R_wen = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
      clear_inputs();
   endtask

   task automatic expect_out(input string nm, input logic rv, input logic [31:0] pc,
                             input logic ifs, input logic ids, input logic fl, input logic clr,
                             input logic [1:0] f1, input logic [1:0] f2);
      exp_t e;
      e = '{rv, pc, ifs, ids, fl, clr, f1, f2};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;

      // Reset with a jump present: outputs must stay 0.
      next_cycle(); reset = 1'b1; ex_valid = 1'b1; ex_jump_flag = 1'b1; ex_branch_pc = 32'h1234;
      expect_out("reset_gate", 0, 32'h0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      expect_out("idle_run", 0, 32'h0, 0, 0, 0, 0, 0, 0);

      // Load-use on rs1=x5.
      next_cycle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
      ex_valid = 1; ex_rd = 5; ex_R_wen = 1; ex_mem_ren = 1;
      expect_out("load_use_stall", 0, 32'h0, 1, 1, 0, 1, 0, 0);
      next_cycle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
      mem_rd = 5; mem_R_wen = 1; mem_mem_ren = 1;
      expect_out("load_in_mem_fwd", 0, 32'h0, 0, 0, 0, 0, 2, 0);

      // Taken branch, then one FLUSH cycle that ignores another take.
      next_cycle(); ex_valid = 1; ex_branch_flag = 1; ex_result0 = 1; ex_branch_pc = 32'h8000_0040;
      expect_out("branch_taken", 1, 32'h8000_0040, 0, 0, 1, 1, 0, 0);
      next_cycle(); ex_valid = 1; ex_jump_flag = 1; ex_branch_pc = 32'h0000_0100;
      expect_out("flush_ignores_take", 0, 32'h0, 0, 0, 1, 1, 0, 0);
      next_cycle();
      expect_out("back_to_run", 0, 32'h0, 0, 0, 0, 0, 0, 0);

      // Not-taken branch, then jump with result0=0.
      next_cycle(); ex_valid = 1; ex_branch_flag = 1; ex_result0 = 0; ex_branch_pc = 32'h0000_0200;
      expect_out("branch_not_taken", 0, 32'h0, 0, 0, 0, 0, 0, 0);
      next_cycle(); ex_valid = 1; ex_jump_flag = 1; ex_result0 = 0; ex_branch_pc = 32'h0000_2000;
      expect_out("jump_taken", 1, 32'h0000_2000, 0, 0, 1, 1, 0, 0);
      next_cycle();
      expect_out("jump_flush", 0, 32'h0, 0, 0, 1, 1, 0, 0);

      // Load in EX matching rs2 together with a jump: redirect wins.
      next_cycle(); id_valid = 1; id_rs2 = 9; id_rs2_used = 1;
      ex_valid = 1; ex_rd = 9; ex_R_wen = 1; ex_mem_ren = 1; ex_jump_flag = 1; ex_branch_pc = 32'h0000_3000;
      expect_out("take_beats_lu", 1, 32'h0000_3000, 0, 0, 1, 1, 0, 0);
      next_cycle();
      expect_out("take_beats_lu_flush", 0, 32'h0, 0, 0, 1, 1, 0, 0);

      // Forwarding priority.
      next_cycle(); id_rs1 = 7; id_rs2 = 7; ex_valid = 1; ex_rd = 7; ex_R_wen = 1;
      mem_rd = 7; mem_R_wen = 1; wb_rd = 7; wb_R_wen = 1;
      expect_out("fwd_ex_first", 0, 32'h0, 0, 0, 0, 0, 1, 1);
      next_cycle(); id_rs1 = 7; id_rs2 = 8; ex_valid = 1; ex_rd = 8; ex_R_wen = 1;
      mem_rd = 7; mem_R_wen = 1; wb_rd = 8; wb_R_wen = 1;
      expect_out("fwd_mem_over_wb", 0, 32'h0, 0, 0, 0, 0, 2, 1);
      next_cycle(); id_rs1 = 3; id_rs2 = 3; ex_valid = 0; ex_rd = 3; ex_R_wen = 1;
      wb_rd = 3; wb_R_wen = 1;
      expect_out("fwd_wb_ex_invalid", 0, 32'h0, 0, 0, 0, 0, 3, 3);
      next_cycle(); ex_valid = 1; ex_R_wen = 1; mem_R_wen = 1; wb_R_wen = 1;
      expect_out("fwd_x0", 0, 32'h0, 0, 0, 0, 0, 0, 0);

      // No hazard when the matching source is not read, or the load targets x0.
      next_cycle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 0;
      ex_valid = 1; ex_rd = 5; ex_R_wen = 1; ex_mem_ren = 1;
      expect_out("lu_src_unused", 0, 32'h0, 0, 0, 0, 0, 0, 0);
      next_cycle(); id_valid = 1; id_rs1_used = 1; id_rs2_used = 1;
      ex_valid = 1; ex_R_wen = 1; ex_mem_ren = 1;
      expect_out("lu_x0", 0, 32'h0, 0, 0, 0, 0, 0, 0);

      // Reset during FLUSH, and reset coinciding with a take.
      next_cycle(); ex_valid = 1; ex_jump_flag = 1; ex_branch_pc = 32'h0000_4000;
      expect_out("pre_reset_take", 1, 32'h0000_4000, 0, 0, 1, 1, 0, 0);
      next_cycle(); reset = 1;
      expect_out("reset_in_flush", 0, 32'h0, 0, 0, 0, 0, 0, 0);
      next_cycle(); reset = 1; ex_valid = 1; ex_jump_flag = 1; ex_branch_pc = 32'h0000_5000;
      expect_out("reset_with_take", 0, 32'h0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      expect_out("run_after_reset", 0, 32'h0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
      @(negedge clock);
      n_checks++;
      if (perf_stall_cnt == 32'd0 && perf_flush_cnt == 32'd0) n_pass++;
      else $display("FAIL perf_after_reset: got stall=%0d flush=%0d, want 0 0", perf_stall_cnt, perf_flush_cnt);
`endif

      next_cycle();
      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
